// File: rtl/traffic_phase_arbiter.sv
// traffic_phase_arbiter: round-robin right-of-way arbiter with green/yellow/all-red timing.
// Optional pedestrian walk phase enabled by defining PED_WALK_EN.
module traffic_phase_arbiter #(
  parameter int N_APP     = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_APP-1:0]         req,
`ifdef PED_WALK_EN
  input  logic                     ped_req,
  output logic                     walk,
`endif
  output logic [3*N_APP-1:0]       lights,
  output logic [$clog2(N_APP)-1:0] grant_id,
  output logic                     phase_start
);
  localparam int GW   = $clog2(N_APP);
  localparam int M1   = GREEN_MAX > YELLOW_T ? GREEN_MAX : YELLOW_T;
  localparam int M2   = M1 > ALLRED_T ? M1 : ALLRED_T;
  localparam int TMAX = M2 > WALK_T ? M2 : WALK_T;
  localparam int TW   = $clog2(TMAX) + 1;
`ifdef PED_WALK_EN
  typedef enum logic [1:0] {ALL_RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2, PED_WALK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {ALL_RED = 2'd0, GREEN = 2'd1, YELLOW = 2'd2} state_t;
`endif
  state_t               state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [GW-1:0]        ptr_q, ptr_d, grant_q, grant_d, sel;
  logic [GW-1:0]        grant_id_q, grant_id_d;
  logic [3*N_APP-1:0]   lights_q, lights_d;
  logic                 ps_q, ps_d, competing, live;
`ifdef PED_WALK_EN
  logic                 ped_pend_q, ped_pend_d, walk_q, walk_d;
`endif
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    competing = |(req & ~(N_APP'(1) << grant_q));
`ifdef PED_WALK_EN
    competing = competing | ped_pend_q;
`endif
    // scan downward so the request closest to ptr is written last and wins
    sel = ptr_q;
    for (int i = N_APP - 1; i >= 0; i--)
      if (req[(int'(ptr_q) + i) % N_APP]) sel = GW'((int'(ptr_q) + i) % N_APP);
    case (state_q)
      ALL_RED: begin
        if (timer_q >= TW'(ALLRED_T - 1)) begin
`ifdef PED_WALK_EN
          if (ped_pend_q) state_d = PED_WALK;
          else
`endif
          if (|req) begin
            state_d = GREEN;
            grant_d = sel;
          end
        end
      end
      GREEN: if ((timer_q >= TW'(GREEN_MIN - 1) && competing) ||
                 (timer_q >= TW'(GREEN_MAX - 1) && competing)) state_d = YELLOW;
      YELLOW: begin
        if (timer_q >= TW'(YELLOW_T - 1)) begin
          state_d = ALL_RED;
          ptr_d   = (grant_q == GW'(N_APP - 1)) ? '0 : grant_q + 1'b1;
        end
      end
`ifdef PED_WALK_EN
      PED_WALK: if (timer_q >= TW'(WALK_T - 1)) state_d = ALL_RED;
`endif
      default: state_d = ALL_RED;
    endcase
    timer_d    = (state_d != state_q) ? '0 : (&timer_q ? timer_q : timer_q + 1'b1);
    live       = state_d == GREEN || state_d == YELLOW;
    grant_id_d = live ? grant_d : '0;
    ps_d       = state_d == GREEN && state_q != GREEN;
    lights_d   = '0;
    for (int i = 0; i < N_APP; i++)
      lights_d[3*i +: 3] = (live && GW'(i) == grant_d) ? (state_d == GREEN ? 3'b001 : 3'b010) : 3'b100;
`ifdef PED_WALK_EN
    ped_pend_d = (state_d == PED_WALK && state_q != PED_WALK) ? 1'b0 : (ped_pend_q | ped_req);
    walk_d     = state_d == PED_WALK;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALL_RED;
      timer_q    <= '0;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      ps_q       <= 1'b0;
      lights_q   <= {N_APP{3'b100}};
`ifdef PED_WALK_EN
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ps_q       <= ps_d;
      lights_q   <= lights_d;
`ifdef PED_WALK_EN
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
`endif
    end
  end
  assign lights      = lights_q;
  assign grant_id    = grant_id_q;
  assign phase_start = ps_q;
`ifdef PED_WALK_EN
  assign walk        = walk_q;
`endif
endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// tb_traffic_phase_arbiter: vector table, directed corner sequences and random run against a phase model.
module tb_traffic_phase_arbiter;
  localparam int N = 4, GMIN = 4, YT = 3, ART = 2;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  req = '0;
  logic [11:0] lights;
  logic [1:0]  grant_id;
  logic        phase_start;
  int n_vec = 0, n_mis = 0;
  int m_ph = 0, m_age = 0, m_ptr = 0, m_gnt = 0;
  typedef struct {logic rst; logic [3:0] req; logic [11:0] lights; logic [1:0] gid; logic ps;} vec_t;
  vec_t tbl[14];
  int st_gid[5], st_cyc[5], n_st;
  bit ok;

  always #5 clk = ~clk;

  traffic_phase_arbiter dut (
    .clk(clk), .rst(rst), .req(req),
    .lights(lights), .grant_id(grant_id), .phase_start(phase_start)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // m_ph: 0 = all red, 1 = green, 2 = yellow; m_age = cycles already spent in the phase
  function automatic logic [11:0] exp_lights();
    logic [11:0] l;
    for (int i = 0; i < N; i++)
      l[3*i +: 3] = (m_ph != 0 && i == m_gnt) ? (m_ph == 1 ? 3'b001 : 3'b010) : 3'b100;
    return l;
  endfunction

  task automatic model_step();
    int nxt;
    if (rst) begin
      m_ph = 0; m_age = 0; m_ptr = 0; m_gnt = 0;
      return;
    end
    nxt = m_ph;
    if (m_ph == 0 && m_age >= ART - 1 && req != 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_gnt = (m_ptr + k) % N;
      nxt = 1;
    end else if (m_ph == 1 && m_age >= GMIN - 1 && (req & ~(4'b1 << m_gnt)) != 0) nxt = 2;
    else if (m_ph == 2 && m_age >= YT - 1) begin
      m_ptr = (m_gnt + 1) % N;
      nxt = 0;
    end
    m_age = (nxt != m_ph) ? 0 : m_age + 1;
    m_ph = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_lights", 32'(lights), 32'(exp_lights()));
    chk("model_grant_id", 32'(grant_id), (m_ph != 0) ? 32'(m_gnt) : 32'd0);
    chk("model_phase_start", 32'(phase_start), 32'(m_ph == 1 && m_age == 0));
  endtask

  task automatic wait_start(input int bound, output bit found);
    found = 1'b0;
    for (int c = 0; c < bound && !found; c++) begin
      tick();
      found = phase_start;
    end
    if (!found) chk("wait_phase_start_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 4'b0000, 12'h924, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 4'b0000, 12'h924, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 12'h924, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0001, 12'h921, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0011, 12'h921, 2'd0, 1'b0};
    tbl[5]  = '{1'b0, 4'b0011, 12'h921, 2'd0, 1'b0};
    tbl[6]  = '{1'b0, 4'b0011, 12'h921, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0011, 12'h922, 2'd0, 1'b0};
    tbl[8]  = '{1'b0, 4'b0011, 12'h922, 2'd0, 1'b0};
    tbl[9]  = '{1'b0, 4'b0011, 12'h922, 2'd0, 1'b0};
    tbl[10] = '{1'b0, 4'b0011, 12'h924, 2'd0, 1'b0};
    tbl[11] = '{1'b0, 4'b0011, 12'h924, 2'd0, 1'b0};
    tbl[12] = '{1'b0, 4'b0011, 12'h90C, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 4'b0011, 12'h90C, 2'd1, 1'b0};
    for (int k = 0; k < 14; k++) begin
      rst = tbl[k].rst;
      req = tbl[k].req;
      tick();
      chk($sformatf("tbl%0d_lights", k), 32'(lights), 32'(tbl[k].lights));
      chk($sformatf("tbl%0d_grant_id", k), 32'(grant_id), 32'(tbl[k].gid));
      chk($sformatf("tbl%0d_phase_start", k), 32'(phase_start), 32'(tbl[k].ps));
    end

    // idle hold, then a lone request rests in green
    rst = 1'b1; req = '0; tick(); tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("idle_hold_lights", 32'(lights), 32'h924);
    req = 4'b0001;
    wait_start(10, ok);
    req = 4'b0000;
    for (int c = 0; c < 25; c++) tick();
    chk("rest_green_lights", 32'(lights), 32'h921);

    // all approaches requesting: strict rotation, 9-cycle cadence
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1111; n_st = 0;
    for (int c = 0; c < 100 && n_st < 5; c++) begin
      tick();
      if (phase_start) begin
        st_gid[n_st] = grant_id;
        st_cyc[n_st] = c;
        n_st++;
      end
    end
    chk("rotation_starts", 32'(n_st), 32'd5);
    for (int k = 0; k < n_st; k++) chk($sformatf("rotation_gid%0d", k), 32'(st_gid[k]), 32'(k % N));
    for (int k = 1; k < n_st; k++) chk($sformatf("rotation_gap%0d", k), 32'(st_cyc[k] - st_cyc[k-1]), 32'd9);

    // reset in the middle of approach 2's yellow
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b0011;
    wait_start(20, ok);
    wait_start(20, ok);
    req = 4'b1100;
    wait_start(20, ok);
    chk("pre_reset_gid", 32'(grant_id), 32'd2);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      ok = lights[8:6] == 3'b010;
    end
    chk("reach_yellow2", 32'(ok), 32'd1);
    tick();
    rst = 1'b1; tick();
    chk("mid_yellow_reset_lights", 32'(lights), 32'h924);
    rst = 1'b0; req = 4'b1100;
    wait_start(20, ok);
    chk("post_reset_gid", 32'(grant_id), 32'd2);
    rst = 1'b1; tick();
    rst = 1'b0; req = 4'b1010;
    wait_start(20, ok);
    chk("post_reset_ptr0_gid", 32'(grant_id), 32'd1);

    // random traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0)
        req = ($urandom_range(0, 2) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
